// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: op classes, R-type function
// codes, 4-bit ALU control codes and the sequencer state enum.
package alu_pkg;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_AND   = 2'b11;

  localparam logic [5:0] FUNC_ADD   = 6'b100000;
  localparam logic [5:0] FUNC_SUB   = 6'b100010;
  localparam logic [5:0] FUNC_AND   = 6'b100100;
  localparam logic [5:0] FUNC_OR    = 6'b100101;
  localparam logic [5:0] FUNC_SLT   = 6'b101010;
  localparam logic [5:0] FUNC_NOR   = 6'b100111;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;

  localparam logic [3:0] CTRL_AND   = 4'b0000;
  localparam logic [3:0] CTRL_OR    = 4'b0001;
  localparam logic [3:0] CTRL_ADD   = 4'b0010;
  localparam logic [3:0] CTRL_SUB   = 4'b0110;
  localparam logic [3:0] CTRL_SLT   = 4'b0111;
  localparam logic [3:0] CTRL_NOR   = 4'b1100;
  localparam logic [3:0] CTRL_MULT  = 4'b1000;
  localparam logic [3:0] CTRL_MULTU = 4'b1001;
  localparam logic [3:0] CTRL_MFHI  = 4'b1010;
  localparam logic [3:0] CTRL_MFLO  = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // True for the two control codes that need the iterative multiplier.
  function automatic logic is_mul(input logic [3:0] code);
    return (code == CTRL_MULT) || (code == CTRL_MULTU);
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational op-class / function-field to ALU control-code decoder.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] func,
  output logic [3:0] ctrl
);

  // Op class picks the code directly except for R-type, which looks at func.
  always_comb begin
    ctrl = CTRL_AND;
    case (alu_op)
      ALUOP_ADD: ctrl = CTRL_ADD;
      ALUOP_SUB: ctrl = CTRL_SUB;
      ALUOP_AND: ctrl = CTRL_AND;
      default: begin
        case (func)
          FUNC_ADD:   ctrl = CTRL_ADD;
          FUNC_SUB:   ctrl = CTRL_SUB;
          FUNC_AND:   ctrl = CTRL_AND;
          FUNC_OR:    ctrl = CTRL_OR;
          FUNC_SLT:   ctrl = CTRL_SLT;
          FUNC_NOR:   ctrl = CTRL_NOR;
          FUNC_MULT:  ctrl = CTRL_MULT;
          FUNC_MULTU: ctrl = CTRL_MULTU;
          FUNC_MFHI:  ctrl = CTRL_MFHI;
          FUNC_MFLO:  ctrl = CTRL_MFLO;
          default:    ctrl = CTRL_AND;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Execute-stage ALU with handshake: single-cycle logic/arith ops plus a
// shift-add multiplier (one partial product per cycle) feeding HI/LO.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_aluOp,
  input  logic [5:0]       i_func,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic [3:0]       o_aluControl,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [3:0]              ctrl;
  logic                    accept;
  logic                    mul_signed;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic [WIDTH-1:0]        alu_res;
  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [2*WIDTH-1:0]      mcand;
  logic [2*WIDTH-1:0]      acc;
  logic [2*WIDTH-1:0]      prod;
  logic [WIDTH-1:0]        mplier;
  logic                    neg;

  // Magnitude of an operand; unsigned operands pass through untouched.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic sgn);
    return (sgn && v[WIDTH-1]) ? -v : v;
  endfunction

  // Sign fix-up of the magnitude product when operand signs differ.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic n);
    return n ? -p : p;
  endfunction

  alu_ctrl_decode u_decode (
    .alu_op (i_aluOp),
    .func   (i_func),
    .ctrl   (ctrl)
  );

  assign accept     = i_valid & o_ready;
  assign mul_signed = (ctrl == CTRL_MULT);
  assign a_s        = i_a;
  assign b_s        = i_b;
  assign prod       = apply_sign(acc, neg);

  // Single-cycle result selection; unknown codes fall back to AND.
  always_comb begin
    alu_res = i_a & i_b;
    case (ctrl)
      CTRL_ADD:  alu_res = i_a + i_b;
      CTRL_SUB:  alu_res = i_a - i_b;
      CTRL_OR:   alu_res = i_a | i_b;
      CTRL_NOR:  alu_res = ~(i_a | i_b);
      CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      CTRL_MFHI: alu_res = o_hi;
      CTRL_MFLO: alu_res = o_lo;
      default:   alu_res = i_a & i_b;
    endcase
  end

  // Multiplier datapath: load magnitudes at accept, shift-add while in MUL.
  always_ff @(posedge i_clk) begin
    if (state == ST_IDLE && accept && is_mul(ctrl)) begin
      mcand  <= {{WIDTH{1'b0}}, magnitude(i_a, mul_signed)};
      mplier <= magnitude(i_b, mul_signed);
      acc    <= '0;
      neg    <= mul_signed & (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
    end else if (state == ST_MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Sequencer FSM with registered handshake, result and HI/LO outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      o_ready      <= 1'b0;
      o_valid      <= 1'b0;
      o_result     <= '0;
      o_zero       <= 1'b0;
      o_aluControl <= '0;
      o_hi         <= '0;
      o_lo         <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          o_ready <= 1'b1;
          if (accept) begin
            o_aluControl <= ctrl;
            if (is_mul(ctrl)) begin
              cnt     <= CNT_W'(WIDTH - 1);
              o_ready <= 1'b0;
              state   <= ST_MUL;
            end else begin
              o_result <= alu_res;
              o_zero   <= (alu_res == '0);
              o_valid  <= 1'b1;
            end
          end
        end
        ST_MUL: begin
          if (cnt == '0) state <= ST_FIN;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIN: begin
          o_hi     <= prod[2*WIDTH-1:WIDTH];
          o_lo     <= prod[WIDTH-1:0];
          o_result <= prod[WIDTH-1:0];
          o_zero   <= (prod[WIDTH-1:0] == '0);
          o_valid  <= 1'b1;
          o_ready  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit (WIDTH=32): vector table for the
// single-cycle ops, scoreboard on o_valid, hand sequences for multiply/reset.
module tb_alu_seq_unit;

  logic        clk;
  logic        rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [1:0]  i_aluOp;
  logic [5:0]  i_func;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_zero;
  logic [3:0]  o_aluControl;
  logic [31:0] o_hi;
  logic [31:0] o_lo;

  int checks   = 0;
  int failures = 0;
  int next_id  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  ctrl;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        zero;
    logic [3:0]  ctrl;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[14];

  alu_seq_unit #(.WIDTH(32)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_aluOp      (i_aluOp),
    .i_func       (i_func),
    .i_a          (i_a),
    .i_b          (i_b),
    .o_valid      (o_valid),
    .o_result     (o_result),
    .o_zero       (o_zero),
    .o_aluControl (o_aluControl),
    .o_hi         (o_hi),
    .o_lo         (o_lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one request and record what the unit must return for it.
  task automatic issue(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic [3:0] ctrl);
    exp_t e;
    i_valid = 1'b1;
    i_aluOp = op;
    i_func  = f;
    i_a     = a;
    i_b     = b;
    e.id    = next_id;
    e.res   = res;
    e.zero  = (res == 32'd0);
    e.ctrl  = ctrl;
    next_id++;
    sb.push_back(e);
  endtask

  // Called on the negedge right after a multiply was driven; returns the
  // number of sampled cycles with o_ready low. Optionally pulses i_valid.
  task automatic run_mul(input bit pulse, output int n);
    n = 0;
    @(negedge clk);
    while (o_ready !== 1'b1 && n < 100) begin
      n++;
      if (pulse && n >= 3 && n <= 5) begin
        i_valid = 1'b1;
        i_aluOp = 2'b00;
        i_a     = 32'd1;
        i_b     = 32'd1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge clk);
    end
    i_valid = 1'b0;
  endtask

  // Scoreboard: every o_valid strobe must match the oldest outstanding request.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual=1 expected=0 result=%h", o_result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk($sformatf("op%0d_result", e.id), {32'd0, o_result}, {32'd0, e.res});
        chk($sformatf("op%0d_zero", e.id), {63'd0, o_zero}, {63'd0, e.zero});
        chk($sformatf("op%0d_ctrl", e.id), {60'd0, o_aluControl}, {60'd0, e.ctrl});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    vecs[0]  = '{2'b10, 6'b100010, 32'd5,         32'd7,         32'hFFFFFFFE, 4'b0110};
    vecs[1]  = '{2'b10, 6'b101010, 32'd5,         32'd7,         32'h00000001, 4'b0111};
    vecs[2]  = '{2'b00, 6'b000000, 32'd3,         32'd4,         32'h00000007, 4'b0010};
    vecs[3]  = '{2'b10, 6'b100101, 32'h000000F0,  32'h0000000F,  32'h000000FF, 4'b0001};
    vecs[4]  = '{2'b10, 6'b100111, 32'd0,         32'd0,         32'hFFFFFFFF, 4'b1100};
    vecs[5]  = '{2'b01, 6'b000000, 32'd9,         32'd9,         32'h00000000, 4'b0110};
    vecs[6]  = '{2'b11, 6'b100000, 32'h000000F0,  32'h0000000F,  32'h00000000, 4'b0000};
    vecs[7]  = '{2'b10, 6'b111111, 32'h0000F0F0,  32'h0000FF00,  32'h0000F000, 4'b0000};
    vecs[8]  = '{2'b10, 6'b101010, 32'hFFFFFFFF,  32'd1,         32'h00000001, 4'b0111};
    vecs[9]  = '{2'b10, 6'b101010, 32'd1,         32'hFFFFFFFF,  32'h00000000, 4'b0111};
    vecs[10] = '{2'b10, 6'b100000, 32'hFFFFFFFF,  32'd1,         32'h00000000, 4'b0010};
    vecs[11] = '{2'b10, 6'b100100, 32'hFF00FF00,  32'h0F0F0F0F,  32'h0F000F00, 4'b0000};
    vecs[12] = '{2'b10, 6'b010000, 32'h12345678,  32'h9ABCDEF0,  32'h00000000, 4'b1010};
    vecs[13] = '{2'b00, 6'b100010, 32'd1,         32'd1,         32'h00000002, 4'b0010};

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_aluOp = 2'b00;
    i_func  = 6'd0;
    i_a     = 32'd0;
    i_b     = 32'd0;

    // Power-on reset for two edges, then release.
    @(negedge clk);
    @(negedge clk);
    chk("por_ready", {63'd0, o_ready}, 64'd0);
    chk("por_valid", {63'd0, o_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("por_release_ready", {63'd0, o_ready}, 64'd1);

    // Reset in the middle of traffic.
    issue(2'b00, 6'd0, 32'd2, 32'd2, 32'd4, 4'b0010);
    @(negedge clk);
    rst_n   = 1'b0;
    i_aluOp = 2'b01;
    i_a     = 32'd1;
    i_b     = 32'd1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready",  {63'd0, o_ready}, 64'd0);
    chk("rst_valid",  {63'd0, o_valid}, 64'd0);
    chk("rst_result", {32'd0, o_result}, 64'd0);
    chk("rst_zero",   {63'd0, o_zero}, 64'd0);
    chk("rst_ctrl",   {60'd0, o_aluControl}, 64'd0);
    chk("rst_hi",     {32'd0, o_hi}, 64'd0);
    chk("rst_lo",     {32'd0, o_lo}, 64'd0);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", {63'd0, o_ready}, 64'd1);
    chk("rst_release_valid", {63'd0, o_valid}, 64'd0);

    // Vector table, issued back-to-back.
    for (int i = 0; i < 14; i++) begin
      issue(vecs[i].op, vecs[i].func, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].ctrl);
      @(negedge clk);
    end
    i_valid = 1'b0;
    @(negedge clk);

    // ADD, OR, NOR on consecutive edges: three consecutive strobes.
    issue(2'b00, 6'd0, 32'd3, 32'd4, 32'h7, 4'b0010);
    @(negedge clk);
    chk("b2b_valid0", {63'd0, o_valid}, 64'd1);
    issue(2'b10, 6'b100101, 32'hF0, 32'h0F, 32'hFF, 4'b0001);
    @(negedge clk);
    chk("b2b_valid1", {63'd0, o_valid}, 64'd1);
    issue(2'b10, 6'b100111, 32'd0, 32'd0, 32'hFFFFFFFF, 4'b1100);
    @(negedge clk);
    chk("b2b_valid2", {63'd0, o_valid}, 64'd1);
    i_valid = 1'b0;
    @(negedge clk);
    chk("b2b_valid3", {63'd0, o_valid}, 64'd0);

    // Signed multiply: -3 * 7 = -21.
    issue(2'b10, 6'b011000, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 4'b1000);
    run_mul(1'b0, n);
    chk("mult_busy_cycles", 64'(n), 64'd33);
    chk("mult_valid", {63'd0, o_valid}, 64'd1);
    chk("mult_hi", {32'd0, o_hi}, 64'hFFFFFFFF);
    chk("mult_lo", {32'd0, o_lo}, 64'hFFFFFFEB);
    @(negedge clk);
    chk("mult_valid_drop", {63'd0, o_valid}, 64'd0);

    // Unsigned multiply with ignored requests during MUL, then MFHI right away.
    issue(2'b10, 6'b011001, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFEB, 4'b1001);
    run_mul(1'b1, n);
    chk("multu_busy_cycles", 64'(n), 64'd33);
    chk("multu_hi", {32'd0, o_hi}, 64'h00000006);
    chk("multu_lo", {32'd0, o_lo}, 64'hFFFFFFEB);
    issue(2'b10, 6'b010000, 32'd0, 32'd0, 32'h00000006, 4'b1010);
    @(negedge clk);
    issue(2'b10, 6'b010010, 32'd0, 32'd0, 32'hFFFFFFEB, 4'b1011);
    @(negedge clk);
    i_valid = 1'b0;
    @(negedge clk);

    // Multiply aborted by reset partway through.
    i_valid = 1'b1;
    i_aluOp = 2'b10;
    i_func  = 6'b011000;
    i_a     = 32'hFFFFFFFD;
    i_b     = 32'd7;
    @(negedge clk);
    i_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("abort_busy", {63'd0, o_ready}, 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_valid", {63'd0, o_valid}, 64'd0);
    chk("abort_hi", {32'd0, o_hi}, 64'd0);
    chk("abort_lo", {32'd0, o_lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_ready", {63'd0, o_ready}, 64'd1);
    repeat (40) @(negedge clk);

    // Unknown function falls back to AND.
    issue(2'b10, 6'b111111, 32'hFFFF0000, 32'h12345678, 32'h12340000, 4'b0000);
    @(negedge clk);
    i_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, handshaked successor to the combinational ALU-control decoder: decodes `i_aluOp`/`i_func` into a 4-bit ALU control code, executes the operation on WIDTH-bit operands, and adds an iterative multiplier with HI/LO registers (`mult`, `multu`, `mfhi`, `mflo`). It sits in the execute stage between the register-file read and the writeback mux.

## Interface
- `WIDTH`, 32: operand, result and HI/LO width; must be at least 4.
- `i_clk`  in  1  the single clock; all state updates on its rising edge.
- `i_rst_n`  in  1  reset, synchronous and active-low.
- `i_valid`  in  1  request strobe; an op is accepted on an edge where `i_valid & o_ready`.
- `o_ready`  out  1  unit idle and able to accept.
- `i_aluOp`  in  2  main-decoder op class.
- `i_func`  in  6  R-type function field; used only when `i_aluOp == 2'b10`.
- `i_a`, `i_b`  in  WIDTH  operands, sampled at accept.
- `o_valid`  out  1  one-cycle result strobe; there is no downstream backpressure.
- `o_result`  out  WIDTH  registered result.
- `o_zero`  out  1  registered; set when the result is all zeros.
- `o_aluControl`  out  4  registered control code of the last accepted op.
- `o_hi`, `o_lo`  out  WIDTH  HI/LO product registers.

## Operation
- **Op-class decode:**
  - `aluOp` 00 → ADD (0010).
  - `aluOp` 01 → SUB (0110).
  - `aluOp` 11 → 0000 (AND).
- **`aluOp` 10 function decode:**
  - 100000 → ADD (0010); 100010 → SUB (0110).
  - 100100 → AND (0000); 100101 → OR (0001).
  - 101010 → SLT (0111); 100111 → NOR (1100).
  - 011000 → MULT (1000); 011001 → MULTU (1001).
  - 010000 → MFHI (1010); 010010 → MFLO (1011).
  - Any other function → 0000 (AND).
- **Arithmetic:** ADD and SUB wrap modulo 2^WIDTH, with no overflow flag. SLT is a signed compare; the result is 1 or 0, zero-extended.
- **MFHI/MFLO:** return the current `o_hi`/`o_lo`.
- **Multiplier:** MULT/MULTU use a shift-add loop, one partial product per cycle, for WIDTH iterations on magnitudes. For MULT, operand magnitudes are taken first, and the 2·WIDTH-bit product is negated in FIN when the operand signs differ. `{o_hi,o_lo}` gets the full product and `o_result` gets the low half.
- **FSM:**
  - IDLE: `o_ready`=1. Accepting a single-cycle op stays in IDLE; accepting MULT/MULTU → MUL.
  - MUL: WIDTH cycles, counted by a down-counter; last iteration → FIN.
  - FIN: sign fix-up; writes HI/LO, `o_result`, `o_zero` and `o_valid`; → IDLE.
- `i_valid` outside IDLE is ignored and the request is not queued.
- **Reset:** while `i_rst_n`=0 at an edge, every output clears to 0 (`o_ready`=0, `o_aluControl`=0000, HI/LO=0) and the FSM goes to IDLE. An in-flight multiply is aborted with no `o_valid`. `o_ready`=1 from the first cycle after release.

## Timing
- **Single-cycle op:** accepted at edge E0; `o_valid`=1 during the cycle after E0, with result, zero flag and control code valid. Throughput is 1 op per cycle, back-to-back.
- **Multiply:** accepted at E0.
  - `o_ready`=0 from E0 until E(WIDTH+1).
  - `o_valid`, `o_result` and the new HI/LO are visible after E(WIDTH+1), together with `o_ready`=1.
  - A request presented in that same cycle is accepted at E(WIDTH+2).
- MFHI issued immediately after a multiply returns the new HI, because issue is blocked until HI/LO are written.
- `o_valid` is low in every cycle not listed above. `o_result` holds its last value between strobes.

## Structure
- **Package `alu_pkg`:** aluOp encodings, function-code constants, 4-bit control-code constants and the FSM state enum (IDLE, MUL, FIN).
- **Sub-module `alu_ctrl_decode`:** purely combinational `aluOp`/`func` → control-code mapping, reusable by other stages.
- **Top:** datapath, multiplier registers, iteration counter and FSM.

## Test plan
All scenarios run with WIDTH=32.
- Hold `i_rst_n`=0 for 2 edges mid-traffic → all outputs 0; `o_ready`=1 the cycle after release.
- `aluOp`=10, func 100010, a=5, b=7 → next cycle `o_result`=FFFFFFFE, `o_aluControl`=0110, `o_zero`=0. Same operands with SLT → 00000001.
- ADD 3+4, then OR F0|0F, then NOR 0,0 on consecutive edges → `o_valid` high for 3 consecutive cycles, results 7, FF, FFFFFFFF.
- MULT a=FFFFFFFD, b=7 → `o_ready` low for 33 edges, then HI=FFFFFFFF, LO=FFFFFFEB, `o_result`=FFFFFFEB.
- MULTU with the same operands → HI=00000006, LO=FFFFFFEB. `i_valid` pulsed during MUL is ignored. MFHI issued next → `o_result`=00000006.
- Drop `i_rst_n` at cycle 10 of a multiply → no `o_valid`, HI/LO=0, FSM IDLE. Unknown func 111111 → control 0000, AND result.
